// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC alarm scheduler: slot count, FSM encoding,
// mode bit positions and the power-on slot contents.
package rtc_pkg;

  localparam int NUM_SLOTS = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // cfg_mode is {oneshot, daily, enable}
  localparam int MODE_EN      = 0;
  localparam int MODE_DAILY   = 1;
  localparam int MODE_ONESHOT = 2;

  localparam logic [31:0] DEFAULT_DATE = 32'h2026_0101;
  localparam logic [31:0] DEFAULT_TIME = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] date;
    logic [31:0] tim;
    logic [2:0]  mode;
  } slot_t;

endpackage

// File: rtl/rtc_alarm_cmp.sv
// Combinational match of one alarm slot against the snapshotted date/time.
module rtc_alarm_cmp (
  input  logic [31:0] slot_date,
  input  logic [31:0] slot_time,
  input  logic        enable,
  input  logic        daily,
  input  logic [31:0] snap_date,
  input  logic [31:0] snap_time,
  output logic        match
);

  // A daily alarm ignores the date field entirely.
  assign match = enable && (snap_time == slot_time) && (daily || (snap_date == slot_date));

endmodule

// File: rtl/rtc_alarm_sched.sv
// Alarm scheduler: on each RTC tick, scans all slots one per cycle against a
// snapshot of the current date/time and raises sticky pending flags.
module rtc_alarm_sched
  import rtc_pkg::*;
#(
  parameter int NUM_SLOTS = rtc_pkg::NUM_SLOTS
) (
  input  logic                 rtc_clk,
  input  logic                 resetn,
  input  logic                 tick,
  input  logic [31:0]          cur_date,
  input  logic [31:0]          cur_time,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_idx,
  input  logic [31:0]          cfg_date,
  input  logic [31:0]          cfg_time,
  input  logic [2:0]           cfg_mode,
  input  logic [NUM_SLOTS-1:0] ack,
  input  logic [NUM_SLOTS-1:0] irq_mask,
  output logic [NUM_SLOTS-1:0] pend,
  output logic                 irq,
  output logic                 busy,
  output logic                 overrun,
  output logic [NUM_SLOTS-1:0] slot_en
);

  state_t      state, state_next;
  logic [1:0]  idx, idx_next;
  logic        snap_load, scan_en, overrun_set;
  logic [31:0] snap_date, snap_time;
  slot_t       slots [NUM_SLOTS];
  logic        match, hit;
  logic [NUM_SLOTS-1:0] set_vec;

  always_ff @(posedge rtc_clk) begin
    if (!resetn) begin
      state <= ST_IDLE;
      idx   <= 2'd0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_next  = state;
    idx_next    = idx;
    snap_load   = 1'b0;
    scan_en     = 1'b0;
    overrun_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick) begin
          snap_load  = 1'b1;
          idx_next   = 2'd0;
          state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        scan_en     = 1'b1;
        overrun_set = tick;
        idx_next    = idx + 2'd1;
        if (idx == 2'd3) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge rtc_clk) begin
    if (snap_load) begin
      snap_date <= cur_date;
      snap_time <= cur_time;
    end
  end

  rtc_alarm_cmp u_cmp (
    .slot_date (slots[idx].date),
    .slot_time (slots[idx].tim),
    .enable    (slots[idx].mode[MODE_EN]),
    .daily     (slots[idx].mode[MODE_DAILY]),
    .snap_date (snap_date),
    .snap_time (snap_time),
    .match     (match)
  );

  assign hit = scan_en && match;

  always_comb begin
    set_vec = '0;
    if (hit) set_vec[idx] = 1'b1;
  end

  // NOTE: slot storage is reset because software relies on known defaults after reset.
  always_ff @(posedge rtc_clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slots[i] <= '{date: DEFAULT_DATE, tim: DEFAULT_TIME, mode: 3'b000};
      end
    end else begin
      if (hit && slots[idx].mode[MODE_ONESHOT]) slots[idx].mode[MODE_EN] <= 1'b0;
      // A same-cycle compare already used the old contents; a config write wins the edge.
      if (cfg_we) slots[cfg_idx] <= '{date: cfg_date, tim: cfg_time, mode: cfg_mode};
    end
  end

  always_ff @(posedge rtc_clk) begin
    if (!resetn) begin
      pend    <= '0;
      irq     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      pend    <= (pend & ~ack) | set_vec;
      irq     <= |(pend & ~irq_mask);
      overrun <= overrun | overrun_set;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) slot_en[i] = slots[i].mode[MODE_EN];
  end

  assign busy = (state == ST_SCAN);

endmodule
